mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped serial transmit port on the single-cycle MIPS CPU's data bus, downstream of the core's Address/MemWrite/Write_data/MemRead outputs. Store words to its data register are queued in a small FIFO and shifted out as 8N1 frames on a single `tx` line. STATUS and CTRL registers are readable and writable over the same bus. The bus-side RAM mux selects `rd_data` whenever `hit` is high.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000, base of the 16-byte register window; bits [3:0] must be zero.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 4, entries of 8 bits; power of two, 2..16.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `Address`  in  32  CPU data address.
- `MemWrite`  in  1  CPU store strobe, valid for the whole cycle.
- `Write_data`  in  32  CPU store data.
- `MemRead`  in  1  CPU load strobe.
- `hit`  out  1  combinational; high when `Address[31:4] == BASE_ADDR[31:4]`.
- `rd_data`  out  32  combinational register read data; 0 when `hit` low.
- `tx`  out  1  serial output, idle high.

## Operation
- Register decode uses `Address[3:2]`; `Address[1:0]` is ignored.
  - 0x0 TXDATA: a write pushes `Write_data[7:0]`; reads return 0.
  - 0x4 STATUS (read-only):
    - bit0 full
    - bit1 empty
    - bit2 busy (state != IDLE)
    - bit3 overflow (sticky)
    - bits[8:4] count (0..FIFO_DEPTH)
    - other bits 0.
  - 0x8 CTRL:
    - bit0 enable, read/write.
    - Writing bit1 = 1 clears overflow; bit1 reads 0.
  - 0xC: reserved; reads 0, writes ignored.
- `rd_data` is purely combinational from Address and current state, so a CPU load completes in the same cycle. `MemRead` has no side effects.
- Push occurs when `hit & MemWrite` and offset is 0x0.
  - If count < FIFO_DEPTH, or a pop happens on the same edge, the byte is enqueued.
  - Otherwise the byte is dropped and overflow is set.
- Pop occurs only in IDLE with enable = 1 and count > 0. The head byte loads into the shift register and the state moves to START.
- Transmitter FSM:
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every state entry. The bit index counts 0..7 in DATA.
- Clearing enable mid-frame does not abort the frame. It only blocks the next pop.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. Count is tracked separately, so full and empty are unambiguous.
- Reset (rst=0 at an edge):
  - state IDLE, tx=1, FIFO empty, pointers 0, overflow 0, enable 1.
  - Any in-flight frame is abandoned immediately; tx is 1 in the cycle after the edge.

## Timing
- Push at edge N: count and STATUS reflect it from cycle N+1.
- Pop in IDLE at edge N: START from cycle N+1, tx=0 from cycle N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles, from the first START cycle through the last STOP cycle.
- Back-to-back frames have exactly one IDLE cycle (tx=1) between STOP and the next START.
- Overflow sets on the edge of the dropped write. If the clear and a dropped write occur in the same cycle, overflow stays set.
- `hit` and `rd_data` have zero-cycle latency. `tx` is driven directly from a flop, so it is glitch-free.

## Test plan
- Reset, then read STATUS at 0xFFFF_0004 -> 32'h0000_0002 (empty=1); `tx`=1; `rd_data`=0 for Address 0x0000_1000 with `hit`=0.
- Store 0x0000_00A5 to 0xFFFF_0000, CLKS_PER_BIT=16 -> tx sequence as 16-cycle bits: 0, 1,0,1,0,0,1,0,1, 1. Frame lasts 160 cycles; busy=1 throughout, 0 afterwards.
- Five consecutive stores (bytes 0x01..0x05) with enable=0, depth 4 -> count=4, full=1, overflow=1, `tx` stays 1.
  - Write CTRL = 0x3 -> overflow clears.
  - Exactly 0x01..0x04 are transmitted in order, with one IDLE cycle between frames.
- With FIFO full and the transmitter popping on the same edge as a store of 0x55 -> 0x55 is accepted, count stays 4, overflow stays 0.
- Deassert `rst` for one cycle 40 cycles into a frame -> next cycle tx=1, STATUS=0x2, and no further frame starts.
- Store to 0xFFFF_000C and 0xFFFF_0003 (offset 0x0, low bits ignored) -> the first has no effect; the second pushes Write_data[7:0].

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: a TXDATA store feeds a small byte FIFO
// that drains through a start/data/stop shift FSM. STATUS and CTRL are exposed on the same window.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  output logic        hit,
  output logic [31:0] rd_data,
  output logic        tx
);

  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  DEPTH_C  = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [15:0]     r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [4:0]      r_count;
  logic            r_ovf;
  logic            r_en;

  logic            w_hit;
  logic [1:0]      w_off;
  logic            w_push;
  logic            w_ctrl_wr;
  logic            w_pop;
  logic            w_accept;
  logic            w_drop;
  logic            w_baud_end;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_hit      = (Address[31:4] == BASE_ADDR[31:4]);
  assign w_off      = Address[3:2];
  assign w_push     = w_hit & MemWrite & (w_off == 2'd0);
  assign w_ctrl_wr  = w_hit & MemWrite & (w_off == 2'd2);
  assign w_pop      = (r_state == S_IDLE) & r_en & (r_count != 5'd0);
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_accept   = w_push & ((r_count < DEPTH_C) | w_pop);
  assign w_drop     = w_push & ~w_accept;
  assign w_baud_end = (r_baud == BAUD_MAX);
  assign w_status   = {23'd0, r_count, r_ovf, (r_state != S_IDLE),
                       (r_count == 5'd0), (r_count == DEPTH_C)};
  assign w_unused   = &{1'b0, MemRead, Address[1:0], Write_data[31:8]};

  assign hit = w_hit;
  assign tx  = r_tx;

  // Register read mux, zero-latency and side-effect free.
  always_comb begin
    rd_data = 32'd0;
    if (w_hit) begin
      case (w_off)
        2'd1:    rd_data = w_status;
        2'd2:    rd_data = {31'd0, r_en};
        default: rd_data = 32'd0;
      endcase
    end else begin
      rd_data = 32'd0;
    end
  end

  // FIFO storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fifo[r_wp] <= Write_data[7:0];
    end
  end

  // FIFO pointers, occupancy, sticky overflow and enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= 5'd0;
      r_ovf   <= 1'b0;
      r_en    <= 1'b1;
    end else begin
      if (w_accept) r_wp <= r_wp + PW'(1);
      if (w_pop)    r_rp <= r_rp + PW'(1);
      r_count <= r_count + {4'd0, w_accept} - {4'd0, w_pop};
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_ctrl_wr & Write_data[1]) begin
        r_ovf <= 1'b0;
      end
      if (w_ctrl_wr) r_en <= Write_data[0];
    end
  end

  // Transmit FSM with registered line output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_state <= S_START;
            r_shift <= r_fifo[r_rp];
            r_baud  <= 16'd0;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_state <= S_DATA;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= 16'd0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= 16'd0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a queue-based model predicts frames and registers,
// a line receiver decodes tx and checks each frame against the expected queue.
module tb_mmio_uart_tx;

  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk;
  logic        rst;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        hit;
  logic [31:0] rd_data;
  logic        tx;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .Address(Address), .MemWrite(MemWrite),
    .Write_data(Write_data), .MemRead(MemRead), .hit(hit), .rd_data(rd_data), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] m_fifo[$];
  int         m_rem;
  bit         m_ovf;
  bit         m_en;
  int         cyc;
  int         rst_gen;
  int         errors;
  int         checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {23'd0, 5'(m_fifo.size()), m_ovf, (m_rem != 0),
            (m_fifo.size() == 0), (m_fifo.size() == DEPTH)};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd1:    return m_status();
      2'd2:    return {31'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: FIFO as a queue, transmitter as a 160-cycle busy window.
  initial begin
    bit     pop, wr, dropped;
    frame_t fr;
    m_rem = 0; m_ovf = 0; m_en = 1; cyc = 0; rst_gen = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_fifo.delete();
        exp_q.delete();
        m_rem = 0; m_ovf = 0; m_en = 1;
        rst_gen++;
      end else begin
        pop = (m_rem == 0) && m_en && (m_fifo.size() > 0);
        wr  = (Address[31:4] == BASE[31:4]) && MemWrite;
        if (pop) begin
          fr.data  = m_fifo.pop_front();
          fr.start = cyc;
          exp_q.push_back(fr);
          m_rem = FRAME;
        end else if (m_rem > 0) begin
          m_rem--;
        end
        dropped = 0;
        if (wr && Address[3:2] == 2'd0) begin
          if (m_fifo.size() < DEPTH) m_fifo.push_back(Write_data[7:0]);
          else begin m_ovf = 1; dropped = 1; end
        end
        if (wr && Address[3:2] == 2'd2) begin
          m_en = Write_data[0];
          if (Write_data[1] && !dropped) m_ovf = 0;
        end
      end
    end
  end

  // Line must idle high whenever the model says no frame is in flight.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && m_rem == 0) chk("idle_tx", {31'd0, tx}, 32'd1);
    end
  end

  int         mon_st, mon_g, mon_bad;
  bit         mon_ok;
  logic [9:0] mon_want;
  logic       mon_samp[FRAME];
  logic [7:0] mon_byte;
  frame_t     mon_e;

  // Receiver: captures a full frame off tx and scores it against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        mon_st = cyc; mon_g = rst_gen; mon_ok = 1; mon_samp[0] = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (rst_gen != mon_g) begin mon_ok = 0; break; end
          mon_samp[i] = tx;
        end
        if (mon_ok) begin
          for (int k = 0; k < 8; k++) mon_byte[k] = mon_samp[CPB + CPB*k + CPB/2];
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_unexpected: got byte %h at cycle %0d expected none", mon_byte, mon_st);
          end else begin
            mon_e = exp_q.pop_front();
            chk("frame_start", mon_st, mon_e.start);
            chk("frame_data", {24'd0, mon_byte}, {24'd0, mon_e.data});
            mon_want = {1'b1, mon_e.data, 1'b0};
            mon_bad = 0;
            for (int i = 0; i < FRAME; i++) if (mon_samp[i] !== mon_want[i/CPB]) mon_bad++;
            chk("frame_shape", mon_bad, 0);
          end
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; MemWrite = 1'b1; Write_data = d;
    @(posedge clk); #1;
    MemWrite = 1'b0; Write_data = 32'd0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a);
    Address = a; #1;
    chk({name, "_hit"}, {31'd0, hit}, {31'd0, (a[31:4] == BASE[31:4])});
    chk(name, rd_data, m_read(a));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_rem != 0 || m_fifo.size() != 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_in_time", {31'd0, (n < limit)}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy;
    logic [31:0] a, d;
    int op;
    errors = 0; checks = 0;
    rst = 1'b0; Address = 32'd0; MemWrite = 1'b0; Write_data = 32'd0; MemRead = 1'b0;
    idle(2);
    rst = 1'b1;

    // Reset state
    Address = BASE + 32'h4; #1;
    chk("reset_status", rd_data, 32'h0000_0002);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    Address = 32'h0000_1000; #1;
    chk("miss_hit", {31'd0, hit}, 32'd0);
    chk("miss_rd", rd_data, 32'd0);
    rd_chk("ctrl_reset", BASE + 32'h8);

    // Single frame 0xA5, busy window
    wr(BASE, 32'h0000_00A5);
    Address = BASE + 32'h4; MemRead = 1'b1;
    busy = 0;
    for (int i = 0; i < 170; i++) begin
      #1;
      chk("status_frame", rd_data, m_status());
      if (rd_data[2]) busy++;
      @(posedge clk); #1;
    end
    MemRead = 1'b0;
    chk("busy_cycles", busy, FRAME);
    drain(500);

    // Disabled fill with overflow, then clear and same-edge pop+push
    wr(BASE + 32'h8, 32'h0);
    for (int b = 1; b <= 5; b++) wr(BASE + 32'h3, b);
    Address = BASE + 32'h4; #1;
    chk("full_status", rd_data, 32'h0000_0049);
    rd_chk("full_status_model", BASE + 32'h4);
    idle(20);
    chk("tx_disabled", {31'd0, tx}, 32'd1);
    wr(BASE + 32'h8, 32'h3);
    Address = BASE + 32'h4; #1;
    chk("ovf_cleared", {31'd0, rd_data[3]}, 32'd0);
    wr(BASE, 32'h0000_0055);
    Address = BASE + 32'h4; #1;
    chk("pop_push_status", rd_data, 32'h0000_0045);
    drain(6000);

    // Reset 40 cycles into a frame with a byte still queued
    wr(BASE, 32'h0000_003C);
    wr(BASE, 32'h0000_007E);
    idle(40);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    Address = BASE + 32'h4; #1;
    chk("abort_status", rd_data, 32'h0000_0002);
    idle(250);

    // Reserved offset ignored, low address bits ignored
    wr(BASE + 32'hC, 32'h0000_0099);
    Address = BASE + 32'h4; #1;
    chk("reserved_status", rd_data, 32'h0000_0002);
    rd_chk("reserved_read", BASE + 32'hC);
    wr(BASE + 32'h3, 32'h1234_5666);
    Address = BASE + 32'h4; #1;
    chk("lowbits_status", rd_data, 32'h0000_0010);
    drain(500);

    // Randomized traffic
    wr(BASE + 32'h8, 32'h1);
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      d = $urandom();
      case (op)
        0, 1, 2, 3, 4: a = BASE + {28'd0, 2'b00, 2'($urandom_range(0, 3))};
        5: begin
          a = BASE + 32'h8;
          d = {d[31:2], 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)};
        end
        6: a = BASE + {28'd0, 2'($urandom_range(1, 3)) == 2'd2 ? 2'd3 : 2'd1, 2'd0};
        7: a = $urandom();
        default: a = ($urandom_range(0, 1) != 0) ? (BASE + {28'd0, 4'($urandom_range(0, 15))}) : $urandom();
      endcase
      rd_chk("rand_rd", a);
      if (op <= 7) wr(a, d);
      else idle(1);
    end
    wr(BASE + 32'h8, 32'h3);
    drain(10000);
    chk("exp_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
